// File: rtl/useq_sequencer.sv
// rtl/useq_sequencer.sv - microprogram sequencer: micro-PC, next-address select, run/halt, retire count
module useq_sequencer #(
  parameter int             AW        = 5,
  parameter int             CW        = 35,
  parameter logic [AW-1:0]  LAST_ADDR = 5'd25,
  parameter logic [4:0]     HALT_OP   = 5'd31
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          stall,
  input  logic [CW-1:0] cs,
  input  logic [4:0]    ir_op,
  input  logic          z_flag,
  output logic [AW-1:0] addr,
  output logic          ctrl_valid,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   instr_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;

  logic [AW-1:0] nxt_addr;
  logic          halt_op, bad_addr, retire;

  logic          cs_nxt_disp;
  logic          cs_brz;
  logic [AW-1:0] cs_nxt;
  logic          unused_cs;

  assign cs_nxt      = cs[AW-1:0];
  assign cs_nxt_disp = cs[5];
  assign cs_brz      = cs[6];
  assign unused_cs   = ^cs[CW-1:7];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    nxt_addr = '0;
    halt_op  = 1'b0;
    bad_addr = 1'b0;
    retire   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (cs_nxt_disp) begin
            if (ir_op == HALT_OP) begin
              halt_op = 1'b1;
            end else if (AW'(ir_op) > LAST_ADDR) begin
              bad_addr = 1'b1;
            end else begin
              nxt_addr = AW'(ir_op);
            end
          end else begin
            nxt_addr = (cs_brz && z_flag) ? '0 : cs_nxt;
            bad_addr = (nxt_addr > LAST_ADDR);
          end

          // An illegal-address halt is a fault, not the end of an instruction.
          if (halt_op || bad_addr) begin
            state_d = ST_HALT;
            addr_d  = '0;
            err_d   = err_q | bad_addr;
            retire  = halt_op;
          end else begin
            addr_d = nxt_addr;
            retire = (nxt_addr == '0) && (addr_q != '0);
          end

          if (retire && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: begin
        addr_d = '0;
        if (start) begin
          state_d = ST_RUN;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign addr       = addr_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_HALT);
  assign ctrl_valid = busy && !stall;
  assign err        = err_q;
  assign instr_cnt  = cnt_q;

endmodule
